// File: rtl/ring_meter_pkg.sv
// Shared types and helpers for the ring-oscillator frequency meter:
// measurement state encoding, Gray decoding and saturating accumulation.
package ring_meter_pkg;

    // Widest value the helpers operate on; callers zero-extend into this
    // width and truncate the result back to their own width.
    localparam int MAX_W = 64;

    // Measurement sequence: wait, snapshot counters, accumulate, publish.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } meter_state_t;

    // Gray to binary for any width up to MAX_W. Zero-extended inputs decode
    // correctly because the leading zeros contribute nothing to the XOR chain.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b = '0;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Largest value representable in w bits (w below MAX_W).
    function automatic logic [MAX_W-1:0] max_of_width(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // a + b clamped to 2^w-1. Operands are assumed to be well below 2^63 so
    // the 64-bit sum itself cannot wrap.
    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int unsigned      w);
        logic [MAX_W-1:0] s;
        s = a + b;
        return (s > max_of_width(w)) ? max_of_width(w) : s;
    endfunction

    // True when a + b would not fit in w bits, i.e. sat_add clamps.
    function automatic logic add_ovf(input logic [MAX_W-1:0] a,
                                     input logic [MAX_W-1:0] b,
                                     input int unsigned      w);
        return ((a + b) > max_of_width(w));
    endfunction

endpackage

// File: rtl/ring_gray_meter_gray_sync.sv
// One channel of the capture path: two-flop synchroniser on a Gray-coded
// counter followed by a combinational Gray-to-binary decode. Only one bit of
// the Gray word changes per ring edge, so whatever the first flop samples is
// either the old or the new count, never a mix.
module gray_sync
    import ring_meter_pkg::*;
#(
    parameter int CW = 12
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [CW-1:0] i_gray,
    output logic [CW-1:0] o_bin
);

    logic [CW-1:0] r_sync1;
    logic [CW-1:0] r_sync2;

    // Two-stage resynchronisation of the asynchronous Gray counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_gray;
            r_sync2 <= r_sync1;
        end
    end

    assign o_bin = CW'(gray2bin(MAX_W'(r_sync2)));

endmodule

// File: rtl/ring_gray_meter.sv
// Multi-channel ring-oscillator frequency meter. Each channel's Gray counter
// is synchronised and decoded, then per-cycle increments are summed over a
// programmable gate of i_clk cycles. Results saturate at 2^AW-1 and are
// published together with overflow and range flags when the gate closes.
module ring_gray_meter
    import ring_meter_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 12,
    parameter int AW  = 16,
    parameter int GW  = 16
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [NCH*CW-1:0]                   i_gray,
    input  logic [GW-1:0]                       i_gate_len,
    input  logic                                i_start,
    input  logic                                i_cont,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] i_sel,
    output logic                                o_busy,
    output logic                                o_valid,
    output logic [AW-1:0]                       o_result,
    output logic [NCH-1:0]                      o_ovf,
    output logic [NCH-1:0]                      o_rng
);

    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    meter_state_t  r_state;
    meter_state_t  w_state_next;
    logic [GW-1:0] r_gate_cnt;
    logic          w_last_gate;
    logic [AW-1:0] w_result_arr [NCH];
    logic [AW-1:0] w_result;

    // The final gate cycle: accumulators take their last increment here and
    // the published results are loaded with that same final value, so they
    // are already stable while o_valid is high.
    assign w_last_gate = (r_state == ST_GATE) && (r_gate_cnt == GW'(1));

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_valid      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                o_busy       = 1'b1;
                w_state_next = ST_GATE;
            end
            ST_GATE: begin
                o_busy = 1'b1;
                if (w_last_gate) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_valid      = 1'b1;
                w_state_next = i_cont ? ST_ARM : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Gate length counter: loaded when arming (a length of 0 still gives a
    // one-cycle gate), counted down through the gate.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_gate_cnt <= '0;
        end else begin
            case (r_state)
                ST_ARM:  r_gate_cnt <= (i_gate_len == '0) ? GW'(1) : i_gate_len;
                ST_GATE: r_gate_cnt <= r_gate_cnt - GW'(1);
                default: r_gate_cnt <= r_gate_cnt;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CW-1:0] w_bin;
            logic [CW-1:0] w_delta;
            logic [AW-1:0] w_acc_next;
            logic          w_ovf_step;
            logic          w_rng_step;
            logic [CW-1:0] r_prev;
            logic [AW-1:0] r_acc;
            logic          r_ovf_wk;
            logic          r_rng_wk;
            logic [AW-1:0] r_result;
            logic          r_ovf_out;
            logic          r_rng_out;

            gray_sync #(
                .CW(CW)
            ) u_sync (
                .i_clk  (i_clk),
                .i_rst_n(i_rst_n),
                .i_gray (i_gray[gi*CW +: CW]),
                .o_bin  (w_bin)
            );

            // Edges seen this cycle; modulo subtraction absorbs counter wrap.
            assign w_delta    = w_bin - r_prev;
            assign w_acc_next = AW'(sat_add(MAX_W'(r_acc), MAX_W'(w_delta), AW));
            assign w_ovf_step = add_ovf(MAX_W'(r_acc), MAX_W'(w_delta), AW);
            // A step of half the counter range or more cannot be told apart
            // from a backwards step: the ring is too fast for this CW.
            assign w_rng_step = w_delta[CW-1];

            // Per-channel accumulation and result publication.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_prev    <= '0;
                    r_acc     <= '0;
                    r_ovf_wk  <= 1'b0;
                    r_rng_wk  <= 1'b0;
                    r_result  <= '0;
                    r_ovf_out <= 1'b0;
                    r_rng_out <= 1'b0;
                end else begin
                    case (r_state)
                        ST_ARM: begin
                            r_prev   <= w_bin;
                            r_acc    <= '0;
                            r_ovf_wk <= 1'b0;
                            r_rng_wk <= 1'b0;
                        end
                        ST_GATE: begin
                            r_prev   <= w_bin;
                            r_acc    <= w_acc_next;
                            r_ovf_wk <= r_ovf_wk | w_ovf_step;
                            r_rng_wk <= r_rng_wk | w_rng_step;
                            if (w_last_gate) begin
                                r_result  <= w_acc_next;
                                r_ovf_out <= r_ovf_wk | w_ovf_step;
                                r_rng_out <= r_rng_wk | w_rng_step;
                            end
                        end
                        default: begin
                            r_prev <= r_prev;
                        end
                    endcase
                end
            end

            assign w_result_arr[gi] = r_result;
            assign o_ovf[gi]        = r_ovf_out;
            assign o_rng[gi]        = r_rng_out;
        end
    endgenerate

    // Readout mux; selections beyond the last channel read as zero.
    always_comb begin
        w_result = '0;
        for (int k = 0; k < NCH; k++) begin
            if (i_sel == SW'(k)) begin
                w_result = w_result_arr[k];
            end
        end
    end

    assign o_result = w_result;

endmodule

// File: tb/tb_ring_gray_meter.sv
// Directed bench for ring_gray_meter with three channels, so that select
// value 3 addresses a channel that does not exist.
module tb_ring_gray_meter;

    localparam int NCH = 3;
    localparam int CW  = 12;
    localparam int AW  = 16;
    localparam int GW  = 16;

    logic              clk;
    logic              i_rst_n;
    logic [NCH*CW-1:0] i_gray;
    logic [GW-1:0]     i_gate_len;
    logic              i_start;
    logic              i_cont;
    logic [1:0]        i_sel;
    logic              o_busy;
    logic              o_valid;
    logic [AW-1:0]     o_result;
    logic [NCH-1:0]    o_ovf;
    logic [NCH-1:0]    o_rng;

    int checks   = 0;
    int failures = 0;

    logic [CW-1:0] cnt  [NCH];
    int            step [NCH];

    ring_gray_meter #(
        .NCH(NCH), .CW(CW), .AW(AW), .GW(GW)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (i_rst_n),
        .i_gray    (i_gray),
        .i_gate_len(i_gate_len),
        .i_start   (i_start),
        .i_cont    (i_cont),
        .i_sel     (i_sel),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_result  (o_result),
        .o_ovf     (o_ovf),
        .o_rng     (o_rng)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         gate;
        int         st0, st1, st2;
        int         c0, c1, c2;
        int         r0, r1, r2;
        logic [2:0] ovf;
        logic [2:0] rng;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic drive_gray();
        for (int k = 0; k < NCH; k++) begin
            i_gray[k*CW +: CW] = cnt[k] ^ (cnt[k] >> 1);
        end
    endtask

    // One clock: outputs are stable 1 time unit after the edge, and the
    // ring counters advance at that point.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < NCH; k++) begin
            cnt[k] = cnt[k] + CW'(step[k]);
        end
        drive_gray();
    endtask

    task automatic read_sel(input int s, output logic [AW-1:0] r);
        i_sel = 2'(s);
        #1;
        r = o_result;
    endtask

    // Pulse start and watch the whole measurement. vtick is the tick index
    // of the first o_valid (-1 if none); bad counts o_busy samples outside
    // ticks 1..eff+1 and any repeated o_valid. With poke set, i_start is
    // raised again while the gate is running.
    task automatic run_meas(input int n, input bit poke, output int vtick, output int bad);
        int eff;
        eff   = (n == 0) ? 1 : n;
        vtick = -1;
        bad   = 0;
        i_gate_len = GW'(n);
        i_start    = 1'b1;
        for (int k = 1; k <= eff + 12; k++) begin
            tick();
            i_start = (poke && k >= 4 && k <= 7) ? 1'b1 : 1'b0;
            if (o_valid) begin
                if (vtick < 0) vtick = k;
                else bad++;
            end
            if (o_busy !== ((k >= 1) && (k <= eff + 1))) bad++;
        end
        i_start = 1'b0;
    endtask

    initial begin
        int            vt, bb, bad, nv, first, last, eff;
        logic [AW-1:0] r;

        vecs[0] = '{"basic",   100, 3,    7,    0,    0,    0, 0,    300,   700,   0,     3'b000, 3'b000};
        vecs[1] = '{"wrap",    10,  13,   0,    5,    4000, 0, 4070, 130,   0,     50,    3'b000, 3'b000};
        vecs[2] = '{"sat_rng", 100, 1000, 2100, 2047, 0,    0, 0,    65535, 65535, 65535, 3'b111, 3'b010};
        vecs[3] = '{"gate0",   0,   4,    0,    9,    0,    0, 0,    4,     0,     9,     3'b000, 3'b000};
        vecs[4] = '{"sat_edge",257, 255,  256,  0,    0,    0, 0,    65535, 65535, 0,     3'b010, 3'b000};
        vecs[5] = '{"rng_edge",1,   2048, 2047, 1,    0,    0, 0,    2048,  2047,  1,     3'b000, 3'b001};

        clk        = 1'b0;
        i_rst_n    = 1'b0;
        i_start    = 1'b1;
        i_cont     = 1'b0;
        i_sel      = 2'd0;
        i_gate_len = GW'(5);
        i_gray     = '0;
        for (int k = 0; k < NCH; k++) begin
            cnt[k]  = CW'($urandom);
            step[k] = $urandom_range(1, 50);
        end
        drive_gray();

        // Reset held with start asserted and counters running.
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (o_busy !== 1'b0 || o_valid !== 1'b0) bad++;
        end
        chk("rst_busy_valid_errs", 64'(bad), 64'd0);
        chk("rst_ovf", 64'(o_ovf), 64'd0);
        chk("rst_rng", 64'(o_rng), 64'd0);
        for (int s = 0; s < NCH; s++) begin
            read_sel(s, r);
            chk($sformatf("rst_result_ch%0d", s), 64'(r), 64'd0);
        end
        i_start = 1'b0;
        i_rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_busy", 64'(o_busy), 64'd0);

        // Table of measurements.
        for (int v = 0; v < 6; v++) begin
            step[0] = vecs[v].st0; step[1] = vecs[v].st1; step[2] = vecs[v].st2;
            cnt[0] = CW'(vecs[v].c0); cnt[1] = CW'(vecs[v].c1); cnt[2] = CW'(vecs[v].c2);
            drive_gray();
            repeat (4) tick();
            eff = (vecs[v].gate == 0) ? 1 : vecs[v].gate;
            run_meas(vecs[v].gate, 1'b0, vt, bb);
            chk({vecs[v].name, "_valid_tick"}, 64'(vt), 64'(eff + 2));
            chk({vecs[v].name, "_busy_errs"}, 64'(bb), 64'd0);
            read_sel(0, r); chk({vecs[v].name, "_ch0"}, 64'(r), 64'(vecs[v].r0));
            read_sel(1, r); chk({vecs[v].name, "_ch1"}, 64'(r), 64'(vecs[v].r1));
            read_sel(2, r); chk({vecs[v].name, "_ch2"}, 64'(r), 64'(vecs[v].r2));
            read_sel(3, r); chk({vecs[v].name, "_sel3"}, 64'(r), 64'd0);
            chk({vecs[v].name, "_ovf"}, 64'(o_ovf), 64'(vecs[v].ovf));
            chk({vecs[v].name, "_rng"}, 64'(o_rng), 64'(vecs[v].rng));
        end

        // i_start raised during the gate must not extend or restart it.
        step[0] = 2; step[1] = 0; step[2] = 0;
        repeat (4) tick();
        run_meas(20, 1'b1, vt, bb);
        chk("poke_valid_tick", 64'(vt), 64'd22);
        chk("poke_busy_errs", 64'(bb), 64'd0);
        read_sel(0, r); chk("poke_ch0", 64'(r), 64'd40);

        // Continuous mode: o_valid every 22 cycles for a 20-cycle gate.
        step[0] = 3; step[1] = 1; step[2] = 0;
        repeat (4) tick();
        i_cont     = 1'b1;
        i_gate_len = GW'(20);
        i_start    = 1'b1;
        nv = 0; first = -1; last = -1; bad = 0;
        for (int k = 1; k <= 110; k++) begin
            tick();
            i_start = 1'b0;
            if (k == 70) i_cont = 1'b0;
            if (o_valid) begin
                if (first < 0) first = k;
                else if (k - last != 22) bad++;
                last = k;
                nv++;
            end
        end
        chk("cont_first_valid", 64'(first), 64'd22);
        chk("cont_period_errs", 64'(bad), 64'd0);
        chk("cont_valid_count", 64'(nv), 64'd4);
        read_sel(0, r); chk("cont_ch0", 64'(r), 64'd60);
        read_sel(1, r); chk("cont_ch1", 64'(r), 64'd20);

        // Reset in the middle of the gate aborts and clears everything.
        i_gate_len = GW'(50);
        i_start    = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            i_start = 1'b0;
        end
        chk("abort_busy_before", 64'(o_busy), 64'd1);
        i_rst_n = 1'b0;
        tick();
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_valid", 64'(o_valid), 64'd0);
        i_rst_n = 1'b1;
        nv = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (o_valid || o_busy) nv++;
        end
        chk("abort_late_activity", 64'(nv), 64'd0);
        read_sel(0, r); chk("abort_ch0", 64'(r), 64'd0);
        read_sel(1, r); chk("abort_ch1", 64'(r), 64'd0);
        chk("abort_ovf", 64'(o_ovf), 64'd0);
        chk("abort_rng", 64'(o_rng), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ring_gray_meter.md
Name: ring_gray_meter

Overview:
- Multi-channel frequency meter in the i_clk domain.
- Each channel receives a free-running Gray-coded edge counter from a ring-oscillator domain. The block synchronises and decodes each counter, then accumulates per-cycle increments over a programmable gate window of i_clk cycles.
- Results are saturating counts, selectable for display and scan logic.
- Generalises the fixed single-ring capture path to NCH channels, with configurable width, gate length, one-shot or continuous mode, and overflow flags.

Parameters:
- NCH, 4, number of ring channels.
- CW, 12, width of each incoming Gray counter.
- AW, 16, accumulator/result width; must be >= CW.
- GW, 16, gate-length counter width.

Ports:
- i_clk  in  1  system clock; sole clock of the block.
- i_rst_n  in  1  synchronous active-low reset.
- i_gray  in  NCH*CW  Gray counters, asynchronous to i_clk; channel k at [k*CW +: CW].
- i_gate_len  in  GW  gate length in i_clk cycles; sampled in ARM.
- i_start  in  1  begin measurement; honoured only in IDLE.
- i_cont  in  1  continuous mode; sampled in DONE.
- i_sel  in  max(1,$clog2(NCH))  readout channel select.
- o_busy  out  1  high in ARM and GATE.
- o_valid  out  1  one-cycle pulse, asserted in DONE.
- o_result  out  AW  result of channel i_sel; 0 if i_sel >= NCH.
- o_ovf  out  NCH  per-channel saturation flag for the last completed measurement.
- o_rng  out  NCH  per-channel range warning for the last completed measurement.

Behaviour:
- Clock and reset:
  - Reset is synchronous and active-low; it takes priority over everything.
  - Reset values: state IDLE; o_busy=0, o_valid=0, o_ovf=0, o_rng=0, all results=0, all synchroniser flops=0.
  - Reset mid-ARM or mid-GATE aborts the measurement: no o_valid, prior results cleared.
- Synchroniser path:
  - Each channel passes through a 2-flop synchroniser, then gray2bin.
  - The decoded value bin_k therefore lags i_gray by 2 cycles.
- State machine, IDLE -> ARM -> GATE -> DONE:
  - IDLE: on i_start=1 -> ARM. i_start in any other state is ignored.
  - ARM (1 cycle):
    - prev_k <= bin_k; acc_k <= 0; ovf/rng working flags cleared.
    - gate_cnt <= i_gate_len, with 0 treated as 1.
    - -> GATE.
  - GATE (i_gate_len cycles), each cycle:
    - d_k = (bin_k - prev_k) mod 2^CW; prev_k <= bin_k.
    - acc_k <= min(acc_k + d_k, 2^AW-1); ovf_k set if the sum exceeds 2^AW-1.
    - rng_k set if d_k >= 2^(CW-1): ring too fast to be unambiguous.
    - gate_cnt decrements; when gate_cnt==1 -> DONE.
  - DONE (1 cycle):
    - result_k <= acc_k; o_ovf <= ovf; o_rng <= rng; o_valid=1.
    - -> ARM if i_cont=1, else -> IDLE.
- Timing:
  - Start sampled in cycle t: ARM at t+1, GATE t+2..t+1+N, DONE (o_valid) at t+2+N.
  - Continuous period is N+2 cycles.
- Wrap-around: counter rollover is handled by modulo subtraction. Gray input is the only legal CDC encoding.
- Results and flags hold until the next DONE or reset. o_result is a combinational mux over the result registers.

Decomposition:
- Package ring_meter_pkg:
  - state encoding (IDLE, ARM, GATE, DONE);
  - function gray2bin (parametrised by width);
  - saturating-add helper.
- Sub-module gray_sync:
  - 2-flop synchroniser plus gray2bin for one channel;
  - parameter CW; ports i_clk, i_rst_n, i_gray, o_bin;
  - instantiated NCH times via generate.

Test Plan:
- Reset: hold i_rst_n=0 with random i_gray -> o_result=0, o_valid=0, o_busy=0, o_ovf=0, o_rng=0; i_start during reset has no effect.
- Basic count: ch0 Gray counter +3/cycle, ch1 +7/cycle, i_gate_len=100, pulse i_start:
  - o_valid exactly at t+102;
  - i_sel=0 -> 300, i_sel=1 -> 700;
  - o_busy high for cycles t+1..t+101.
- Wrap: CW=12, ch2 starts at 4090 and steps +5/cycle, gate 10 -> result 50, o_ovf[2]=0, o_rng[2]=0.
- Saturation/range:
  - AW=16, +1000/cycle, gate 100 -> result 65535, o_ovf=1.
  - +2100/cycle (>=2048) -> o_rng=1.
- Continuous and abort:
  - i_cont=1, gate 20 -> o_valid pulses every 22 cycles.
  - Drop i_rst_n in mid-GATE -> no further o_valid, o_busy=0 next cycle, results 0.
- Edge cases:
  - i_gate_len=0 -> 1-cycle gate, o_valid at t+3.
  - i_sel=NCH -> o_result=0.
  - i_start during GATE is ignored.
